divsqrt_arbiter: RTL and testbench

DIVSQRT_ARBITER -- requirements
Module: divsqrt_arbiter

---
 rtl/divsqrt_arbiter.sv | 138 +++++++++++++
 tb/tb_divsqrt_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/divsqrt_arbiter.sv
// Round-robin arbiter sharing one divSqrtFN unit among NUM_REQ requesters, one operation in flight.
// Accept in IDLE, unit_inValid the next cycle, response the cycle after unit_outValid; stalls hold ISSUE/RESP.

module divsqrt_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int expWidth = 8,
    parameter int sigWidth = 24
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ-1:0]                      req_sqrtOp,
    input  logic [NUM_REQ*(expWidth+sigWidth)-1:0]  req_a,
    input  logic [NUM_REQ*(expWidth+sigWidth)-1:0]  req_b,
    input  logic [NUM_REQ*3-1:0]                    req_roundingMode,
    input  logic                                    unit_inReady,
    output logic                                    unit_inValid,
    output logic                                    unit_sqrtOp,
    output logic [expWidth+sigWidth-1:0]            unit_a,
    output logic [expWidth+sigWidth-1:0]            unit_b,
    output logic [2:0]                              unit_roundingMode,
    input  logic                                    unit_outValid,
    input  logic [expWidth+sigWidth-1:0]            unit_out,
    input  logic [4:0]                              unit_exceptionFlags,
    output logic [NUM_REQ-1:0]                      resp_valid,
    input  logic [NUM_REQ-1:0]                      resp_ready,
    output logic [expWidth+sigWidth-1:0]            resp_out,
    output logic [4:0]                              resp_exceptionFlags,
    output logic [15:0]                             ops_done
);

    localparam int FW = expWidth + sigWidth;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t              state_q;
    logic [IW-1:0]       last_grant_q;
    logic [IW-1:0]       grant_q;
    logic [IW-1:0]       grant_d;
    logic                grant_found;
    logic [IW-1:0]       cand;
    int                  idx;
    logic                sqrt_q;
    logic [FW-1:0]       a_q;
    logic [FW-1:0]       b_q;
    logic [2:0]          rm_q;
    logic                in_valid_q;
    logic [NUM_REQ-1:0]  resp_valid_q;
    logic [FW-1:0]       resp_out_q;
    logic [4:0]          resp_flags_q;
    logic [15:0]         ops_done_q;

    // Search starts just after the last served requester so every one gets a turn.
    always_comb begin
        grant_d     = '0;
        grant_found = 1'b0;
        cand        = '0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IW'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_d     = cand;
            end
        end
        req_ready = '0;
        if (state_q == IDLE && grant_found && !reset) req_ready[grant_d] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            grant_q      <= '0;
            sqrt_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            rm_q         <= '0;
            in_valid_q   <= 1'b0;
            resp_valid_q <= '0;
            resp_out_q   <= '0;
            resp_flags_q <= '0;
            ops_done_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        grant_q    <= grant_d;
                        sqrt_q     <= req_sqrtOp[grant_d];
                        a_q        <= req_a[int'(grant_d)*FW +: FW];
                        b_q        <= req_b[int'(grant_d)*FW +: FW];
                        rm_q       <= req_roundingMode[int'(grant_d)*3 +: 3];
                        in_valid_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (unit_inReady) begin
                        in_valid_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (unit_outValid) begin
                        resp_out_q   <= unit_out;
                        resp_flags_q <= unit_exceptionFlags;
                        resp_valid_q <= NUM_REQ'(1) << grant_q;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[grant_q]) begin
                        resp_valid_q <= '0;
                        last_grant_q <= grant_q;
                        ops_done_q   <= ops_done_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign unit_inValid        = in_valid_q;
    assign unit_sqrtOp         = sqrt_q;
    assign unit_a              = a_q;
    assign unit_b              = b_q;
    assign unit_roundingMode   = rm_q;
    assign resp_valid          = resp_valid_q;
    assign resp_out            = resp_out_q;
    assign resp_exceptionFlags = resp_flags_q;
    assign ops_done            = ops_done_q;

endmodule

// File: tb/tb_divsqrt_arbiter.sv
// Directed bench for divsqrt_arbiter; the bench plays the role of the shared divSqrtFN unit.

module tb_divsqrt_arbiter;

    localparam int N  = 4;
    localparam int FW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_sqrtOp;
    logic [N*FW-1:0]   req_a;
    logic [N*FW-1:0]   req_b;
    logic [N*3-1:0]    req_roundingMode;
    logic              unit_inReady;
    logic              unit_inValid;
    logic              unit_sqrtOp;
    logic [FW-1:0]     unit_a;
    logic [FW-1:0]     unit_b;
    logic [2:0]        unit_roundingMode;
    logic              unit_outValid;
    logic [FW-1:0]     unit_out;
    logic [4:0]        unit_exceptionFlags;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [FW-1:0]     resp_out;
    logic [4:0]        resp_exceptionFlags;
    logic [15:0]       ops_done;

    logic [FW-1:0]     a_v [N];
    logic [FW-1:0]     b_v [N];
    logic              sq_v [N];
    logic [2:0]        rm_v [N];

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_ops = 16'd0;

    divsqrt_arbiter #(.NUM_REQ(N), .expWidth(8), .sigWidth(24)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_sqrtOp(req_sqrtOp),
        .req_a(req_a), .req_b(req_b), .req_roundingMode(req_roundingMode),
        .unit_inReady(unit_inReady), .unit_inValid(unit_inValid), .unit_sqrtOp(unit_sqrtOp),
        .unit_a(unit_a), .unit_b(unit_b), .unit_roundingMode(unit_roundingMode),
        .unit_outValid(unit_outValid), .unit_out(unit_out), .unit_exceptionFlags(unit_exceptionFlags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
        .resp_exceptionFlags(resp_exceptionFlags), .ops_done(ops_done)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*FW +: FW]          = a_v[i];
            req_b[i*FW +: FW]          = b_v[i];
            req_sqrtOp[i]              = sq_v[i];
            req_roundingMode[i*3 +: 3] = rm_v[i];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one granted operation through the unit and back to the requester.
    task automatic serve(input int g, input logic [31:0] res, input logic [4:0] fl,
                         input int stall_in, input int stall_resp);
        int n;
        logic [N-1:0] oh;
        oh = N'(1) << g;
        n = 0;
        while (!unit_inValid && n < 20) begin
            tick();
            n++;
        end
        chk("issue_seen", unit_inValid, 1);
        chk("unit_a", unit_a, a_v[g]);
        chk("unit_b", unit_b, b_v[g]);
        chk("unit_sqrtOp", unit_sqrtOp, sq_v[g]);
        chk("unit_rm", unit_roundingMode, rm_v[g]);
        unit_inReady = 1'b0;
        for (int s = 0; s < stall_in; s++) begin
            tick();
            chk("issue_hold_valid", unit_inValid, 1);
            chk("issue_hold_a", unit_a, a_v[g]);
            chk("issue_no_accept", req_ready, 0);
        end
        unit_inReady = 1'b1;
        tick();
        chk("busy_no_invalid", unit_inValid, 0);
        tick();
        chk("busy_no_resp", resp_valid, 0);
        unit_outValid = 1'b1;
        unit_out = res;
        unit_exceptionFlags = fl;
        tick();
        unit_outValid = 1'b0;
        unit_out = 32'hDEADBEEF;
        unit_exceptionFlags = 5'b11111;
        chk("resp_valid", resp_valid, oh);
        chk("resp_out", resp_out, res);
        chk("resp_flags", resp_exceptionFlags, fl);
        chk("resp_no_invalid", unit_inValid, 0);
        resp_ready = ~oh;
        for (int s = 0; s < stall_resp; s++) begin
            tick();
            chk("resp_hold_valid", resp_valid, oh);
            chk("resp_hold_out", resp_out, res);
            chk("resp_hold_ops", ops_done, exp_ops);
            chk("resp_no_accept", req_ready, 0);
        end
        resp_ready = oh;
        tick();
        resp_ready = '0;
        exp_ops = exp_ops + 16'd1;
        chk("resp_cleared", resp_valid, 0);
        chk("ops_done", ops_done, exp_ops);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a_v[i]  = 32'h0;
            b_v[i]  = 32'h0;
            sq_v[i] = 1'b0;
            rm_v[i] = 3'(i);
        end
        reset = 1'b1;
        req_valid = 4'b1111;
        unit_inReady = 1'b1;
        unit_outValid = 1'b0;
        unit_out = '0;
        unit_exceptionFlags = '0;
        resp_ready = '0;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_inValid", unit_inValid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_out", resp_out, 0);
        chk("rst_flags", resp_exceptionFlags, 0);
        chk("rst_ops", ops_done, 0);
        chk("rst_unit_a", unit_a, 0);
        req_valid = '0;
        reset = 1'b0;
        tick();

        // Single divide on requester 0; valid drops right after accept.
        a_v[0] = 32'h3F800000; b_v[0] = 32'h40000000; sq_v[0] = 1'b0; rm_v[0] = 3'd0;
        req_valid = 4'b0001;
        #1;
        chk("t1_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        serve(0, 32'h3F000000, 5'b00000, 0, 0);

        // Square root on requester 2.
        a_v[2] = 32'h40800000; b_v[2] = 32'h0; sq_v[2] = 1'b1;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        serve(2, 32'h40000000, 5'b00000, 0, 0);

        // Divide by zero on requester 3, leaving last_grant at 3.
        a_v[3] = 32'h3F800000; b_v[3] = 32'h00000000; sq_v[3] = 1'b0;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        serve(3, 32'h7F800000, 5'b01000, 0, 0);

        // Fairness with everyone valid: expect 0,1,2,3,0.
        a_v[1] = 32'h11111111; b_v[1] = 32'h22222222; sq_v[1] = 1'b0;
        req_valid = 4'b1111;
        serve(0, 32'h00001000, 5'b00001, 0, 0);
        serve(1, 32'h00001001, 5'b00010, 0, 0);
        serve(2, 32'h00001002, 5'b00100, 0, 0);
        serve(3, 32'h00001003, 5'b10000, 0, 0);
        serve(0, 32'h00001004, 5'b00000, 0, 0);

        // Stalls on both handshakes with all others still requesting.
        serve(1, 32'h0BADCAFE, 5'b00011, 5, 3);
        req_valid = '0;
        tick();

        // Reset while BUSY, then a spurious unit_outValid must be ignored.
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        chk("pre_rst_busy", unit_inValid, 0);
        reset = 1'b1;
        #1;
        exp_ops = 16'd0;
        chk("mid_rst_inValid", unit_inValid, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_ops", ops_done, 0);
        chk("mid_rst_unit_a", unit_a, 0);
        chk("mid_rst_resp_out", resp_out, 0);
        tick();
        reset = 1'b0;
        unit_outValid = 1'b1;
        unit_out = 32'h12345678;
        tick();
        unit_outValid = 1'b0;
        tick();
        chk("spurious_resp_valid", resp_valid, 0);
        chk("spurious_resp_out", resp_out, 0);
        req_valid = 4'b1111;
        #1;
        chk("post_rst_grant0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        serve(0, 32'h3F800000, 5'b00000, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
